// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Frame = start bit (0), DATA_WIDTH data bits
//                LSB first, optional parity bit, one stop bit (1).
//                RXD is brought into the clk domain through a 2-flop
//                synchroniser, the start bit is validated at mid-bit and each
//                following bit is sampled at its centre. The received word is
//                presented with a one-cycle rx_done strobe and error flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_FREQ   : system clock frequency in Hz
//    BAUD_RATE  : line bit rate
//    PARITY     : "NONE", "ODD" or "EVEN" (anything else behaves as "NONE")
//    DATA_WIDTH : data bits per frame
//  Ports
//    clk        : in  system clock, rising edge
//    srst       : in  synchronous active-high reset
//    RXD        : in  serial line, asynchronous to clk, idle high
//    rx_data    : out last received word, held until next rx_done
//    rx_done    : out one-cycle pulse, frame complete
//    parity_err : out parity mismatch of last frame (0 when PARITY="NONE")
//    frame_err  : out stop bit sampled 0 in last frame
//    rx_busy    : out high whenever the receiver is not idle
//  Build option
//    UART_RX_MAJORITY_EN : when defined, every bit decision is a 2-of-3 vote
//                          of rxd_s at target-1, target and target+1 (decided
//                          at target+1). Needs CLK_FREQ/BAUD_RATE-1 >= 4.
// ============================================================================
module uart_rx #(
    parameter int    CLK_FREQ   = 50_000_000,
    parameter int    BAUD_RATE  = 9600,
    parameter string PARITY     = "NONE",
    parameter int    DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  RXD,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);

    // ------------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------------
    localparam int c_BIT_CNT  = CLK_FREQ / BAUD_RATE - 1;
    localparam int c_HALF_CNT = c_BIT_CNT / 2;

`ifdef UART_RX_MAJORITY_EN
    // Decisions are taken one count late; reloading the counter with 1
    // instead of 0 keeps the bit period at exactly c_BIT_CNT+1 clocks.
    localparam int c_OFFSET = 1;
`else
    localparam int c_OFFSET = 0;
`endif

    localparam int c_CNT_MAX = c_BIT_CNT + c_OFFSET;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);
    localparam int c_BC_W    = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_TGT  = c_CNT_W'(c_BIT_CNT + c_OFFSET);
    localparam logic [c_CNT_W-1:0] c_HALF_TGT = c_CNT_W'(c_HALF_CNT + c_OFFSET);
    localparam logic [c_CNT_W-1:0] c_RELOAD   = c_CNT_W'(c_OFFSET);
    localparam logic [c_BC_W-1:0]  c_LAST_BIT = c_BC_W'(DATA_WIDTH - 1);

    localparam bit c_PAR_ODD = (PARITY == "ODD");
    localparam bit c_PAR_EN  = (PARITY == "ODD") || (PARITY == "EVEN");

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_PARI  = 3'd3;
    localparam logic [2:0] c_S_STOP  = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic                  r_sync1;
    logic                  r_sync2;      // rxd_s
    logic                  r_prev;       // rxd_s one cycle earlier
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_BC_W-1:0]     r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_err_nx;
    logic                  r_frm_err_nx;

    logic                  w_fall;
    logic                  w_sample;
    logic                  w_hit;
    logic [DATA_WIDTH:0]   w_shift;

    assign w_fall  = r_prev & ~r_sync2;
    assign w_shift = {w_sample, r_data};
    assign rx_busy = (r_state != c_S_IDLE);

    // Bit-centre reached for the current state.
    assign w_hit = (r_state == c_S_START) ? (r_cnt == c_HALF_TGT)
                                          : (r_cnt == c_BIT_TGT);

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] holds rxd_s at target, r_hist[1] at target-1 when the
    // decision is taken at target+1.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    assign w_sample = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) |
                      (r_hist[0] & r_hist[1]);
`else
    assign w_sample = r_sync2;
`endif

    // ------------------------------------------------------------------------
    // Receiver state machine, synchroniser and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= c_S_IDLE;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_par_err_nx <= 1'b0;
            r_frm_err_nx <= 1'b0;
            rx_data      <= '0;
            rx_done      <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            rx_done <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (w_fall) begin
                        r_state <= c_S_START;
                    end
                end

                c_S_START: begin
                    if (w_hit) begin
                        if (!w_sample) begin
                            r_state <= c_S_DATA;
                            r_cnt   <= c_RELOAD;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            r_state <= c_S_IDLE;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_DATA: begin
                    if (w_hit) begin
                        r_data <= w_shift[DATA_WIDTH:1];
                        r_cnt  <= c_RELOAD;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_PAR_EN ? c_S_PARI : c_S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_PARI: begin
                    if (w_hit) begin
                        // Even: sample must equal XOR(data); odd: its inverse.
                        r_par_err_nx <= w_sample ^ (^r_data) ^ c_PAR_ODD;
                        r_cnt        <= c_RELOAD;
                        r_state      <= c_S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_STOP: begin
                    if (w_hit) begin
                        r_frm_err_nx <= ~w_sample;
                        r_cnt        <= '0;
                        r_state      <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_DONE: begin
                    rx_data    <= r_data;
                    parity_err <= r_par_err_nx;
                    frame_err  <= r_frm_err_nx;
                    rx_done    <= 1'b1;
                    r_state    <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx. Two receivers (PARITY "NONE"
//                and "EVEN", 16 clk per bit) each have their own serial line.
//                Stimulus pushes the expected word/flags into a queue; a
//                monitor per receiver pops and compares on every rx_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_BIT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk   = 1'b0;
    logic       srst  = 1'b1;
    logic       rxd_n = 1'b1;
    logic       rxd_e = 1'b1;

    logic [7:0] data_n, data_e;
    logic       done_n, done_e;
    logic       perr_n, perr_e;
    logic       ferr_n, ferr_e;
    logic       busy_n, busy_e;

    exp_t       q_n[$];
    exp_t       q_e[$];

    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .PARITY     ("NONE"),
        .DATA_WIDTH (8)
    ) u_dut_none (
        .clk        (clk),
        .srst       (srst),
        .RXD        (rxd_n),
        .rx_data    (data_n),
        .rx_done    (done_n),
        .parity_err (perr_n),
        .frame_err  (ferr_n),
        .rx_busy    (busy_n)
    );

    uart_rx #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .PARITY     ("EVEN"),
        .DATA_WIDTH (8)
    ) u_dut_even (
        .clk        (clk),
        .srst       (srst),
        .RXD        (rxd_e),
        .rx_data    (data_e),
        .rx_done    (done_e),
        .parity_err (perr_e),
        .frame_err  (ferr_e),
        .rx_busy    (busy_e)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        return e;
    endfunction

    // Drive nb line bits, LSB first, one bit period each.
    task automatic send(input bit sel_even, input int nb, input logic [15:0] bits);
        for (int i = 0; i < nb; i++) begin
            if (sel_even) rxd_e = bits[i];
            else          rxd_n = bits[i];
            repeat (c_BIT) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while ((q_n.size() != 0 || q_e.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q_n.size() != 0 || q_e.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: pending none=%0d even=%0d, required 0",
                     nm, q_n.size(), q_e.size());
            q_n.delete();
            q_e.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (done_n === 1'b1) begin
            if (q_n.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL none_unexpected_done: actual rx_done=1 data=%0h, required no frame", data_n);
            end else begin
                exp_t e;
                e = q_n.pop_front();
                chk("none_data", data_n, e.data);
                chk("none_perr", {7'd0, perr_n}, {7'd0, e.perr});
                chk("none_ferr", {7'd0, ferr_n}, {7'd0, e.ferr});
            end
        end
    end

    always @(negedge clk) begin
        if (done_e === 1'b1) begin
            if (q_e.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL even_unexpected_done: actual rx_done=1 data=%0h, required no frame", data_e);
            end else begin
                exp_t e;
                e = q_e.pop_front();
                chk("even_data", data_e, e.data);
                chk("even_perr", {7'd0, perr_e}, {7'd0, e.perr});
                chk("even_ferr", {7'd0, ferr_e}, {7'd0, e.ferr});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        repeat (4) @(negedge clk);
        srst = 1'b0;
        chk("rst_none_data", data_n, 8'h00);
        chk("rst_none_done", {7'd0, done_n}, 8'h00);
        chk("rst_none_busy", {7'd0, busy_n}, 8'h00);
        chk("rst_none_flags", {6'd0, perr_n, ferr_n}, 8'h00);
        chk("rst_even_flags", {6'd0, perr_e, ferr_e}, 8'h00);
        repeat (5) @(negedge clk);

        // Clean frame, no parity
        q_n.push_back(mk(8'hA5, 1'b0, 1'b0));
        send(1'b0, 10, {1'b1, 8'hA5, 1'b0});
        wait_drain("a5");
        repeat (2) @(negedge clk);
        chk("a5_busy_after", {7'd0, busy_n}, 8'h00);

        // Even parity: correct then wrong parity bit (XOR(07) = 1)
        q_e.push_back(mk(8'h07, 1'b0, 1'b0));
        send(1'b1, 11, {1'b1, 1'b1, 8'h07, 1'b0});
        wait_drain("par_ok");
        q_e.push_back(mk(8'h07, 1'b1, 1'b0));
        send(1'b1, 11, {1'b1, 1'b0, 8'h07, 1'b0});
        wait_drain("par_bad");
        repeat (2) @(negedge clk);
        chk("even_busy_after", {7'd0, busy_e}, 8'h00);

        // Stop bit 0, then break: line stays low for 40 more clocks
        q_n.push_back(mk(8'h3C, 1'b0, 1'b1));
        send(1'b0, 10, {1'b0, 8'h3C, 1'b0});
        wait_drain("brk");
        repeat (40) @(negedge clk);
        chk("brk_no_retrigger_busy", {7'd0, busy_n}, 8'h00);
        chk("brk_ferr_held", {7'd0, ferr_n}, 8'h01);
        rxd_n = 1'b1;
        repeat (c_BIT) @(negedge clk);

        // 3-clock glitch while idle: starts, then abandons at mid start bit
        rxd_n = 1'b0;
        repeat (3) @(negedge clk);
        rxd_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_start_busy", {7'd0, busy_n}, 8'h01);
        repeat (30) @(negedge clk);
        chk("glitch_idle_busy", {7'd0, busy_n}, 8'h00);
        chk("glitch_data_held", data_n, 8'h3C);
        chk("glitch_flags_held", {6'd0, perr_n, ferr_n}, 8'h01);

        // Back-to-back frames with no idle gap
        q_n.push_back(mk(8'h00, 1'b0, 1'b0));
        q_n.push_back(mk(8'hFF, 1'b0, 1'b0));
        send(1'b0, 10, {1'b1, 8'h00, 1'b0});
        send(1'b0, 10, {1'b1, 8'hFF, 1'b0});
        wait_drain("b2b");
        repeat (4) @(negedge clk);

        // Reset half way through the 4th data bit of an A5 frame
        send(1'b0, 4, {12'd0, 4'b1010});
        rxd_n = 1'b0;
        repeat (8) @(negedge clk);
        srst  = 1'b1;
        rxd_n = 1'b1;
        @(negedge clk);
        srst  = 1'b0;
        chk("abort_none_data", data_n, 8'h00);
        chk("abort_none_flags", {6'd0, perr_n, ferr_n}, 8'h00);
        chk("abort_none_busy", {7'd0, busy_n}, 8'h00);
        chk("abort_even_data", data_e, 8'h00);
        chk("abort_even_perr", {7'd0, perr_e}, 8'h00);
        repeat (3 * c_BIT) @(negedge clk);
        chk("abort_idle_busy", {7'd0, busy_n}, 8'h00);

        q_n.push_back(mk(8'h5A, 1'b0, 1'b0));
        send(1'b0, 10, {1'b1, 8'h5A, 1'b0});
        wait_drain("post_rst");
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
